// File: rtl/branch_target_predictor_pkg.sv
// Shared types and constants for the branch target predictor.
package branch_target_predictor_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } btp_state_t;

    localparam int DEF_PC_WIDTH    = 30;
    localparam int DEF_INDEX_WIDTH = 10;
    localparam int DEF_TAG_WIDTH   = 8;
    localparam int DEF_CTR_WIDTH   = 2;

    // Weakly taken: MSB set, all lower bits clear.
    function automatic int unsigned weak_taken_ctr(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    localparam int unsigned DEF_WEAK_CTR = weak_taken_ctr(DEF_CTR_WIDTH);

endpackage

// File: rtl/branch_target_predictor_if.sv
// Lookup/update bus between the fetch unit and the branch target predictor.
interface branch_target_predictor_if
    import branch_target_predictor_pkg::*;
#(
    parameter int PC_WIDTH = DEF_PC_WIDTH
);
    logic                ready;
    logic [PC_WIDTH-1:0] lk_pc;
    logic                pred_hit;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_next_pc;
    logic                upd_valid;
    logic [PC_WIDTH-1:0] upd_pc;
    logic                upd_taken;
    logic [PC_WIDTH-1:0] upd_target;

    modport master (
        output lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  ready, pred_hit, pred_taken, pred_next_pc
    );

    modport slave (
        input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output ready, pred_hit, pred_taken, pred_next_pc
    );
endinterface

// File: rtl/branch_target_predictor_btb_ram.sv
// Predictor table: one registered read-first lookup port and one write port.
module btb_ram
    import branch_target_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_INDEX_WIDTH,
    parameter int DATA_WIDTH = 1 + DEF_TAG_WIDTH + DEF_CTR_WIDTH + DEF_PC_WIDTH
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] wr_cur
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Read and write in one block: the read sees the old word on a collision.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Current contents at the write address, for read-modify-write updates.
    assign wr_cur = mem[wr_addr];

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor with saturating counters and a
// post-reset clear sweep; predictions come out one cycle after lk_pc.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int CTR_WIDTH   = DEF_CTR_WIDTH
) (
    input  logic clk,
    input  logic rst,
    branch_target_predictor_if.slave bus
);
    if (INDEX_WIDTH + TAG_WIDTH > PC_WIDTH) begin : g_bad_width
        $error("INDEX_WIDTH + TAG_WIDTH must not exceed PC_WIDTH");
    end
    if (CTR_WIDTH < 1) begin : g_bad_ctr
        $error("CTR_WIDTH must be at least 1");
    end

    // Entry layout {valid, tag, ctr, target}
    localparam int DW    = 1 + TAG_WIDTH + CTR_WIDTH + PC_WIDTH;
    localparam int C_LSB = PC_WIDTH;
    localparam int T_LSB = PC_WIDTH + CTR_WIDTH;
    localparam int V_BIT = DW - 1;
    localparam logic [CTR_WIDTH-1:0] WEAK = CTR_WIDTH'(weak_taken_ctr(CTR_WIDTH));

    btp_state_t state, state_nxt;
    logic [INDEX_WIDTH-1:0] sweep_idx;
    logic sweep_en;

    logic [PC_WIDTH-1:0] lk_q;
    logic pred_en_q, pred_zero_q;

    logic [DW-1:0] rd_data, wr_data, wr_cur;
    logic [INDEX_WIDTH-1:0] wr_addr;
    logic wr_en;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (&sweep_idx) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        bus.ready = (state == READY);
        sweep_en  = (state == INIT);
    end

    always_ff @(posedge clk) begin
        if (rst)           sweep_idx <= '0;
        else if (sweep_en) sweep_idx <= sweep_idx + 1'b1;
    end

    // Lookup side: table read and the PC it belongs to land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_q        <= '0;
            pred_en_q   <= 1'b0;
            pred_zero_q <= 1'b1;
        end else begin
            lk_q        <= bus.lk_pc;
            pred_en_q   <= (state == READY);
            pred_zero_q <= 1'b0;
        end
    end

    always_comb begin
        bus.pred_hit = pred_en_q && rd_data[V_BIT] &&
                       (rd_data[T_LSB +: TAG_WIDTH] == lk_q[INDEX_WIDTH +: TAG_WIDTH]);
        bus.pred_taken = bus.pred_hit && rd_data[C_LSB + CTR_WIDTH - 1];
        if (pred_zero_q)         bus.pred_next_pc = '0;
        else if (bus.pred_taken) bus.pred_next_pc = rd_data[PC_WIDTH-1:0];
        else                     bus.pred_next_pc = lk_q + 1'b1;
    end

    // Update side: sweep owns the write port until the table is clear.
    logic                 upd_hit;
    logic [CTR_WIDTH-1:0] cur_ctr, new_ctr;
    logic [TAG_WIDTH-1:0] upd_tag;

    always_comb begin
        upd_tag = bus.upd_pc[INDEX_WIDTH +: TAG_WIDTH];
        cur_ctr = wr_cur[C_LSB +: CTR_WIDTH];
        upd_hit = wr_cur[V_BIT] && (wr_cur[T_LSB +: TAG_WIDTH] == upd_tag);
        if (bus.upd_taken) new_ctr = (&cur_ctr) ? cur_ctr : cur_ctr + 1'b1;
        else               new_ctr = (|cur_ctr) ? cur_ctr - 1'b1 : cur_ctr;

        wr_en   = 1'b0;
        wr_addr = bus.upd_pc[INDEX_WIDTH-1:0];
        wr_data = '0;
        if (sweep_en) begin
            wr_en   = 1'b1;
            wr_addr = sweep_idx;
        end else if (bus.upd_valid) begin
            if (upd_hit) begin
                wr_en   = 1'b1;
                wr_data = {1'b1, upd_tag, new_ctr,
                           bus.upd_taken ? bus.upd_target : wr_cur[PC_WIDTH-1:0]};
            end else if (bus.upd_taken) begin
                wr_en   = 1'b1;
                wr_data = {1'b1, upd_tag, WEAK, bus.upd_target};
            end
        end
    end

    btb_ram #(
        .ADDR_WIDTH (INDEX_WIDTH),
        .DATA_WIDTH (DW)
    ) u_ram (
        .clk     (clk),
        .rd_addr (bus.lk_pc[INDEX_WIDTH-1:0]),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_cur  (wr_cur)
    );

endmodule
